decode_stage: RTL and testbench

- Instruction-decode stage of the RISC-V-lite pipeline.
- Takes the instruction held in the IF/ID slot and drives the register-file read ports: enable, read strobes and source addresses.
- Decodes the RV32I base subset into control fields, immediate, register indices, PC and an illegal flag, held in the ID/EX pipeline register.
- The register file registers its outputs on the same clock edge as ID/EX, so its OUT1/OUT2 are cycle-aligned with ID_* outputs.
- Detects load-use hazards and inserts one bubble; honours downstream backpressure and branch flush.

---
 rtl/rv_pkg.sv | 41 ++++
 rtl/instr_decoder.sv | 106 ++++++++++
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I-lite opcodes, ALU codes and decode control bundle
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;
    logic    mem_rd;
    logic    mem_wr;
    logic    reg_wr;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational RV32I-lite decode: control bundle, immediate, source usage
module instr_decoder
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] imm32;
  imm_fmt_t    fmt;
  ctrl_t       ctrl;
  logic        bad_f7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign bad_f7 = (funct7 != 7'h00) && (funct7 != 7'h20);

  always_comb begin
    ctrl       = '0;
    fmt        = IMM_NONE;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode)
      OPC_LUI:    begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_PASSB; ctrl.alu_src = 1'b1; fmt = IMM_U; end
      OPC_AUIPC:  begin ctrl.reg_wr = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_U; end
      OPC_JAL:    begin ctrl.reg_wr = 1'b1; ctrl.jump = 1'b1; fmt = IMM_J; end
      OPC_JALR: begin
        ctrl.reg_wr = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_I;
        uses_rs1_o = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; fmt = IMM_B;
        uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.mem_rd = 1'b1; ctrl.reg_wr = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_I;
        uses_rs1_o = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_wr = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_S;
        uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.reg_wr = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_I;
        uses_rs1_o = 1'b1;
        case (funct3)
          3'b000:  ctrl.alu_op = ALU_ADD;
          3'b001:  begin ctrl.alu_op = ALU_SLL; ctrl.illegal = bad_f7; end
          3'b010:  ctrl.alu_op = ALU_SLT;
          3'b011:  ctrl.alu_op = ALU_SLTU;
          3'b100:  ctrl.alu_op = ALU_XOR;
          3'b101:  begin ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL; ctrl.illegal = bad_f7; end
          3'b110:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        ctrl.reg_wr = 1'b1;
        uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
        // funct7 0x20 only selects the alternate form of ADD and SRL
        ctrl.illegal = bad_f7 || (funct7[5] && funct3 != 3'b000 && funct3 != 3'b101);
        case (funct3)
          3'b000:  ctrl.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl.alu_op = ALU_SLL;
          3'b010:  ctrl.alu_op = ALU_SLT;
          3'b011:  ctrl.alu_op = ALU_SLTU;
          3'b100:  ctrl.alu_op = ALU_XOR;
          3'b101:  ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (instr_i[11:7] == 5'd0) ctrl.reg_wr = 1'b0;
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign ctrl_o = ctrl;
  assign imm_o  = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: RF read drive, load-use bubble FSM and ID/EX register
module decode_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IF_VALID,
  input  logic [31:0]     IF_INSTR,
  input  logic [XLEN-1:0] IF_PC,
  output logic            IF_READY,
  input  logic            EX_READY,
  input  logic            FLUSH,
  output logic            RF_ENABLE,
  output logic            RF_RD1,
  output logic            RF_RD2,
  output logic [4:0]      RF_ADD_RD1,
  output logic [4:0]      RF_ADD_RD2,
  output logic            ID_VALID,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] ID_IMM,
  output logic [4:0]      ID_RS1,
  output logic [4:0]      ID_RS2,
  output logic [4:0]      ID_RD,
  output logic [3:0]      ID_ALU_OP,
  output logic            ID_ALU_SRC,
  output logic [2:0]      ID_FUNCT3,
  output logic            ID_MEM_RD,
  output logic            ID_MEM_WR,
  output logic            ID_REG_WR,
  output logic            ID_BRANCH,
  output logic            ID_JUMP,
  output logic            ID_ILLEGAL
);

  typedef enum logic {ST_RUN, ST_LU_BUBBLE} state_t;

  state_t          state_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;
  ctrl_t           ctrl_q;

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            uses_rs1, uses_rs2;
  logic            advance, hazard;

  instr_decoder #(.XLEN(XLEN)) u_dec (
    .instr_i    (IF_INSTR),
    .ctrl_o     (dec_ctrl),
    .imm_o      (dec_imm),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  assign RF_ADD_RD1 = IF_INSTR[19:15];
  assign RF_ADD_RD2 = IF_INSTR[24:20];
  assign RF_RD1     = IF_VALID & uses_rs1;
  assign RF_RD2     = IF_VALID & uses_rs2;

  // RF output registers share the ID/EX enable so OUT1/OUT2 stay aligned with ID_*
  assign advance   = EX_READY | FLUSH;
  assign RF_ENABLE = advance;

  assign hazard = valid_q & ctrl_q.mem_rd & (rd_q != 5'd0) & IF_VALID &
                  ((uses_rs1 & (RF_ADD_RD1 == rd_q)) | (uses_rs2 & (RF_ADD_RD2 == rd_q)));

  assign IF_READY = !RESET & EX_READY & !FLUSH & !((state_q == ST_RUN) & hazard);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      ctrl_q   <= '0;
    end else if (advance) begin
      if (FLUSH) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        state_q <= ST_RUN;
      end else if (state_q == ST_RUN && hazard) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        state_q <= ST_LU_BUBBLE;
      end else begin
        state_q <= ST_RUN;
        if (IF_VALID) begin
          valid_q  <= 1'b1;
          pc_q     <= IF_PC;
          imm_q    <= dec_imm;
          rs1_q    <= IF_INSTR[19:15];
          rs2_q    <= IF_INSTR[24:20];
          rd_q     <= IF_INSTR[11:7];
          funct3_q <= IF_INSTR[14:12];
          ctrl_q   <= dec_ctrl;
        end else begin
          valid_q <= 1'b0;
          ctrl_q  <= '0;
        end
      end
    end
  end

  assign ID_VALID   = valid_q;
  assign ID_PC      = pc_q;
  assign ID_IMM     = imm_q;
  assign ID_RS1     = rs1_q;
  assign ID_RS2     = rs2_q;
  assign ID_RD      = rd_q;
  assign ID_ALU_OP  = ctrl_q.alu_op;
  assign ID_ALU_SRC = ctrl_q.alu_src;
  assign ID_FUNCT3  = funct3_q;
  assign ID_MEM_RD  = ctrl_q.mem_rd;
  assign ID_MEM_WR  = ctrl_q.mem_wr;
  assign ID_REG_WR  = ctrl_q.reg_wr;
  assign ID_BRANCH  = ctrl_q.branch;
  assign ID_JUMP    = ctrl_q.jump;
  assign ID_ILLEGAL = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h80;
  localparam int NP = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_VALID, EX_READY, FLUSH;
  logic [31:0] IF_INSTR, IF_PC;
  logic        IF_READY, RF_ENABLE, RF_RD1, RF_RD2;
  logic [4:0]  RF_ADD_RD1, RF_ADD_RD2;
  logic        ID_VALID;
  logic [31:0] ID_PC, ID_IMM;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD;
  logic [3:0]  ID_ALU_OP;
  logic        ID_ALU_SRC;
  logic [2:0]  ID_FUNCT3;
  logic        ID_MEM_RD, ID_MEM_WR, ID_REG_WR, ID_BRANCH, ID_JUMP, ID_ILLEGAL;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC),
    .IF_READY(IF_READY), .EX_READY(EX_READY), .FLUSH(FLUSH), .RF_ENABLE(RF_ENABLE),
    .RF_RD1(RF_RD1), .RF_RD2(RF_RD2), .RF_ADD_RD1(RF_ADD_RD1), .RF_ADD_RD2(RF_ADD_RD2),
    .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_IMM(ID_IMM), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_RD(ID_RD), .ID_ALU_OP(ID_ALU_OP), .ID_ALU_SRC(ID_ALU_SRC), .ID_FUNCT3(ID_FUNCT3),
    .ID_MEM_RD(ID_MEM_RD), .ID_MEM_WR(ID_MEM_WR), .ID_REG_WR(ID_REG_WR),
    .ID_BRANCH(ID_BRANCH), .ID_JUMP(ID_JUMP), .ID_ILLEGAL(ID_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // fl = {mem_rd, mem_wr, reg_wr, branch, jump, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src;
    logic [5:0]  fl;
    logic        u1, u2;
    logic [31:0] pc;
  } ent_t;

  ent_t prog [NP];
  ent_t sb [$];
  ent_t cur;
  logic cur_valid;
  int   ptr, errs, checks;
  logic gap;

  function automatic ent_t mk(input logic [31:0] instr, imm, input logic [3:0] alu,
                              input logic src, input logic [5:0] fl, input logic u1, u2);
    ent_t e;
    e.instr = instr; e.imm = imm; e.alu = alu; e.src = src; e.fl = fl;
    e.u1 = u1; e.u2 = u2; e.pc = '0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_id();
    check("id_valid", 32'(ID_VALID), 32'(cur_valid));
    check("id_flags", 32'({ID_MEM_RD, ID_MEM_WR, ID_REG_WR, ID_BRANCH, ID_JUMP, ID_ILLEGAL}),
          cur_valid ? 32'(cur.fl) : 32'd0);
    if (cur_valid) begin
      check("id_pc", ID_PC, cur.pc);
      check("id_imm", ID_IMM, cur.imm);
      check("id_rs1", 32'(ID_RS1), 32'(cur.instr[19:15]));
      check("id_rs2", 32'(ID_RS2), 32'(cur.instr[24:20]));
      check("id_rd", 32'(ID_RD), 32'(cur.instr[11:7]));
      check("id_alu_op", 32'(ID_ALU_OP), 32'(cur.alu));
      check("id_alu_src", 32'(ID_ALU_SRC), 32'(cur.src));
      check("id_funct3", 32'(ID_FUNCT3), 32'(cur.instr[14:12]));
    end
  endtask

  task automatic step(input logic exr, input logic fl, input logic exp_rdy);
    ent_t e;
    logic acc;
    IF_VALID = !gap && (ptr < NP);
    e        = prog[(ptr < NP) ? ptr : 0];
    e.pc     = 32'h200 + 32'(4 * ptr);
    IF_INSTR = IF_VALID ? e.instr : 32'h0;
    IF_PC    = e.pc;
    EX_READY = exr;
    FLUSH    = fl;
    @(negedge CLK);
    check("if_ready", 32'(IF_READY), 32'(exp_rdy));
    check("rf_enable", 32'(RF_ENABLE), 32'(exr | fl));
    if (IF_VALID) begin
      check("rf_add_rd1", 32'(RF_ADD_RD1), 32'(e.instr[19:15]));
      check("rf_add_rd2", 32'(RF_ADD_RD2), 32'(e.instr[24:20]));
      check("rf_rd1", 32'(RF_RD1), 32'(e.u1));
      check("rf_rd2", 32'(RF_RD2), 32'(e.u2));
    end
    acc = exp_rdy & IF_VALID;
    if (acc) begin
      sb.push_back(e);
      ptr++;
    end
    @(posedge CLK);
    #1;
    if (exr | fl) begin
      if (acc && sb.size() > 0) begin
        cur       = sb.pop_front();
        cur_valid = 1'b1;
      end else begin
        cur_valid = 1'b0;
      end
    end
    compare_id();
  endtask

  initial begin
    errs = 0; checks = 0; ptr = 0; gap = 1'b0; cur_valid = 1'b0;
    prog[0]  = mk(32'h00500093, 32'd5,        4'd0,  1'b1, 6'b001000, 1'b1, 1'b0); // addi x1,x0,5
    prog[1]  = mk(32'h00012283, 32'd0,        4'd0,  1'b1, 6'b101000, 1'b1, 1'b0); // lw x5,0(x2)
    prog[2]  = mk(32'h00128333, 32'd0,        4'd0,  1'b0, 6'b001000, 1'b1, 1'b1); // add x6,x5,x1
    prog[3]  = mk(32'h0041A003, 32'd4,        4'd0,  1'b1, 6'b100000, 1'b1, 1'b0); // lw x0,4(x3)
    prog[4]  = mk(32'h000003B3, 32'd0,        4'd0,  1'b0, 6'b001000, 1'b1, 1'b1); // add x7,x0,x0
    prog[5]  = mk(32'hFE208CE3, 32'hFFFFFFF8, 4'd1,  1'b0, 6'b000100, 1'b1, 1'b1); // beq x1,x2,-8
    prog[6]  = prog[1];
    prog[7]  = prog[2];
    prog[8]  = mk(32'h0000007F, 32'd0,        4'd0,  1'b0, 6'b000001, 1'b0, 1'b0); // bad opcode
    prog[9]  = mk(32'h402081B3, 32'd0,        4'd1,  1'b0, 6'b001000, 1'b1, 1'b1); // sub x3,x1,x2
    prog[10] = mk(32'h4030D213, 32'h00000403, 4'd7,  1'b1, 6'b001000, 1'b1, 1'b0); // srai x4,x1,3
    prog[11] = mk(32'h4020C1B3, 32'd0,        4'd0,  1'b0, 6'b000001, 1'b1, 1'b1); // xor with f7=0x20
    prog[12] = mk(32'h0020A623, 32'd12,       4'd0,  1'b1, 6'b010000, 1'b1, 1'b1); // sw x2,12(x1)
    prog[13] = mk(32'h123452B7, 32'h12345000, 4'd10, 1'b1, 6'b001000, 1'b0, 1'b0); // lui x5,0x12345
    prog[14] = prog[1];
    prog[15] = prog[2];

    RESET = 1'b1; IF_VALID = 1'b1; IF_INSTR = prog[0].instr; IF_PC = 32'h200;
    EX_READY = 1'b1; FLUSH = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_id_valid", 32'(ID_VALID), 32'd0);
    check("rst_id_pc", ID_PC, RST_PC);
    check("rst_if_ready", 32'(IF_READY), 32'd0);
    check("rst_id_imm", ID_IMM, 32'd0);
    RESET = 1'b0;

    step(1'b1, 1'b0, 1'b1);                        // addi
    step(1'b1, 1'b0, 1'b1);                        // lw x5
    step(1'b1, 1'b0, 1'b0);                        // add x6 stalls: bubble
    step(1'b1, 1'b0, 1'b1);                        // add x6 accepted
    step(1'b1, 1'b0, 1'b1);                        // lw x0
    step(1'b1, 1'b0, 1'b1);                        // add x7 uses x0: no stall
    repeat (3) step(1'b0, 1'b0, 1'b0);             // backpressure, beq waiting
    step(1'b1, 1'b0, 1'b1);                        // beq
    step(1'b1, 1'b0, 1'b1);                        // lw x5
    step(1'b0, 1'b1, 1'b0);                        // flush with hazard pending
    step(1'b1, 1'b0, 1'b1);                        // add accepted, no extra bubble
    step(1'b0, 1'b1, 1'b0);                        // flush while EX stalled
    for (int i = 8; i < 14; i++) step(1'b1, 1'b0, 1'b1);
    gap = 1'b1;
    step(1'b1, 1'b0, 1'b1);                        // fetch empty: bubble
    gap = 1'b0;
    step(1'b1, 1'b0, 1'b1);                        // lw x5
    step(1'b1, 1'b0, 1'b0);                        // bubble, stall state entered
    #2 RESET = 1'b1;
    #1;
    check("midrst_id_valid", 32'(ID_VALID), 32'd0);
    check("midrst_id_pc", ID_PC, RST_PC);
    check("midrst_if_ready", 32'(IF_READY), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    cur_valid = 1'b0;
    step(1'b1, 1'b0, 1'b1);                        // add accepted straight after reset
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
